// File: rtl/sgd_pkg.sv
// ============================================================================
//  Module  : sgd_pkg
//  Brief   : Shared sizing defaults and loader state encoding for the SGD path.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sgd_pkg;

    localparam int c_word_width   = 16;
    localparam int c_max_features = 15;
    localparam int c_addr_width   = 12;
    localparam int c_rec_width    = c_word_width * (c_max_features + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int rec_width(input int word_w, input int max_feat);
        return word_w * (max_feat + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_deser.sv
// ============================================================================
//  Module  : serial_word_deser
//  Brief   : Collects LANES-bit beats into one word; flags the completing beat.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_deser #(
    parameter int WORD_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [LANES-1:0]      s_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int c_beats = WORD_WIDTH / LANES;
    localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;

    logic [WORD_WIDTH-1:0] r_shift;
    logic [c_bw-1:0]       r_beat;
    logic [WORD_WIDTH-1:0] w_next;
    logic                  w_last;

    assign w_last = (r_beat == c_bw'(c_beats - 1));

    // Lane 0 is always the earliest bit, so it lands furthest from the insertion point.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            logic [LANES-1:0] w_rev;
            always_comb begin
                w_rev = '0;
                for (int i = 0; i < LANES; i++) begin
                    w_rev[i] = s_in[LANES-1-i];
                end
            end
            assign w_next = (r_shift << LANES) | WORD_WIDTH'(w_rev);
        end else begin : g_lsb_first
            assign w_next = (r_shift >> LANES) | (WORD_WIDTH'(s_in) << (WORD_WIDTH - LANES));
        end
    endgenerate

    assign word       = w_next;
    assign word_valid = en && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (clr) begin
            r_shift <= '0;
            r_beat  <= '0;
        end else if (en) begin
            if (w_last) begin
                r_shift <= '0;
                r_beat  <= '0;
            end else begin
                r_shift <= w_next;
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_dataset_loader.sv
// ============================================================================
//  Module  : serial_dataset_loader
//  Brief   : Deserialises training records and writes them into the dataset RAM.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_dataset_loader
    import sgd_pkg::*;
#(
    parameter int WORD_WIDTH   = c_word_width,
    parameter int MAX_FEATURES = c_max_features,
    parameter int ADDR_WIDTH   = c_addr_width,
    parameter int LANES        = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [3:0]                             feat,
    input  logic [ADDR_WIDTH-1:0]                  data_points,
    input  logic [LANES-1:0]                       s_in,
    input  logic                                   s_valid,
    output logic                                   wr_en,
    output logic [ADDR_WIDTH-1:0]                  wr_addr,
    output logic [WORD_WIDTH*(MAX_FEATURES+1)-1:0] wr_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int c_rec_w = rec_width(WORD_WIDTH, MAX_FEATURES);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_feat;
    logic [ADDR_WIDTH-1:0] r_dp;
    logic [ADDR_WIDTH-1:0] r_rec;
    logic [3:0]            r_word_idx;
    logic [c_rec_w-1:0]    r_asm;
    logic [c_rec_w-1:0]    w_masked;
    logic                  r_err;
    logic                  w_feat_bad;
    logic                  w_beat_en;
    logic                  w_deser_clr;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_word_valid;

    assign w_feat_bad  = ({1'b0, feat} > 5'(MAX_FEATURES));
    assign w_beat_en   = (r_state == ST_SHIFT) && s_valid;
    assign w_deser_clr = (r_state != ST_SHIFT);

    serial_word_deser #(
        .WORD_WIDTH (WORD_WIDTH),
        .LANES      (LANES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_deser_clr),
        .en         (w_beat_en),
        .s_in       (s_in),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start && !w_feat_bad) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_word_valid && (r_word_idx == 4'd0)) w_next_state = ST_FLUSH;
            ST_FLUSH: w_next_state = (r_rec == r_dp) ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat     <= '0;
            r_dp       <= '0;
            r_rec      <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_feat_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_feat     <= feat;
                            r_dp       <= data_points;
                            r_word_idx <= feat;
                            r_rec      <= '0;
                            r_asm      <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_word_valid) begin
                        for (int j = 0; j <= MAX_FEATURES; j++) begin
                            if (r_word_idx == 4'(j)) begin
                                r_asm[j*WORD_WIDTH +: WORD_WIDTH] <= w_word;
                            end
                        end
                        if (r_word_idx != 4'd0) begin
                            r_word_idx <= r_word_idx - 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_asm      <= '0;
                    r_word_idx <= r_feat;
                    if (r_rec != r_dp) begin
                        r_rec <= r_rec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Slices above the captured feature count never reach the RAM, whatever they hold.
    always_comb begin
        w_masked = '0;
        for (int j = 0; j <= MAX_FEATURES; j++) begin
            if (4'(j) <= r_feat) begin
                w_masked[j*WORD_WIDTH +: WORD_WIDTH] = r_asm[j*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign wr_en   = (r_state == ST_FLUSH);
    assign wr_addr = r_rec;
    assign wr_data = w_masked;
    assign busy    = (r_state == ST_SHIFT) || (r_state == ST_FLUSH);
    assign done    = (r_state == ST_DONE);
    assign err     = r_err;

endmodule

`default_nettype wire
